conv_stream_ctrl: RTL and testbench
===================================

CONV_STREAM_CTRL -- requirements
Module: conv_stream_ctrl

Interface
REQ-001 SHALL have parameter DIM, 28, image side length in pixels.
REQ-002 SHALL have parameter K, 5, convolution kernel side length.
REQ-003 SHALL have parameter AW, 10, image-memory address width, with 2^AW >= DIM*DIM.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle frame-start request, sampled only in IDLE.
REQ-007 SHALL have port abort  input  1  cancels the frame in progress.
REQ-008 SHALL have port mem_addr  output  AW  pixel address into the synchronous image RAM.
REQ-009 SHALL have port mem_rd_en  output  1  RAM read strobe.
REQ-010 SHALL have port mem_data  input  8  RAM read data, valid 1 cycle after mem_rd_en.
REQ-011 SHALL have port pxl_out  output  8  registered pixel driven to conv pxl_in.
REQ-012 SHALL have port conv_in  input  8  conv pxl_out, result 1 cycle after pxl_out.
REQ-013 SHALL have port out_data / out_valid / out_eol  output  8/1/1  cropped result, qualifier and end-of-output-row flag.
REQ-014 SHALL have port busy / done  output  1/1  busy is high outside IDLE; done is a 1-cycle pulse at frame end.

Function
REQ-015 SHALL implement states IDLE, FETCH, DRAIN and DONE.
REQ-016 SHALL move IDLE->FETCH on start, FETCH->DRAIN after address DIM*DIM-1 is issued, DRAIN->DONE after 4 cycles, and DONE->IDLE after 1 cycle.
REQ-017 SHALL assert mem_rd_en in FETCH and issue addresses 0..DIM*DIM-1 consecutively, one per cycle, with no gaps.
REQ-018 SHALL register mem_data into pxl_out every cycle; pxl_out holds its value when no read is in flight.
REQ-019 SHALL pipeline a pixel index (row r, col c) alongside the data, 4 cycles from address issue to out_data.
REQ-020 SHALL register conv_in into out_data, with out_valid=1 iff the tagged pixel has r>=K-1 and c>=K-1 (subject to CONV_STREAM_CTRL_CROP_EN).
REQ-021 SHALL assert out_eol together with out_valid iff c==DIM-1.
REQ-022 SHALL derive the row/col counters by wrap (c==DIM-1 -> c=0, r++) and SHALL NOT use divide/modulo.
REQ-023 SHALL ignore start when not in IDLE; start asserted together with abort in IDLE SHALL be ignored.
REQ-024 SHALL, on abort in FETCH/DRAIN/DONE, go to IDLE next cycle, deassert mem_rd_en/out_valid immediately, clear in-flight tags, and not pulse done.
REQ-025 SHALL pulse done in the DONE state, exactly 1 cycle after the final out_valid.

Reset
REQ-026 SHALL on reset (asynchronous, active-high) force state=IDLE, mem_addr=0, mem_rd_en=0, pxl_out=0, out_data=0, out_valid=0, out_eol=0, busy=0, done=0, and clear counters and tags.
REQ-027 SHALL treat reset mid-frame like abort, with no done pulse; a new frame SHALL need a fresh start.

Configuration
REQ-028 SHALL define macro CONV_STREAM_CTRL_CROP_EN: when defined, out_valid follows REQ-020, giving (DIM-K+1)^2 outputs per frame.
REQ-029 SHALL, without CONV_STREAM_CTRL_CROP_EN, assert out_valid for all DIM*DIM tagged pixels, with out_eol still on c==DIM-1.

Verification
REQ-030 SHALL cover: reset then start at cycle 0 (CROP_EN, DIM=28, K=5, RAM[i]=i+1 mod 256) -> addresses 0..783 on cycles 1..784, 576 out_valid, first at addr-116 issue +4, done 1 cycle after the last.
REQ-031 SHALL cover: same frame -> exactly 24 out_eol pulses, each on an output with c==27.
REQ-032 SHALL cover: start pulsed again mid-FETCH -> no address restart; still 576 outputs and 1 done.
REQ-033 SHALL cover: abort at address 300 -> IDLE next cycle, out_valid low within 1 cycle, no done; next start yields a full correct frame.
REQ-034 SHALL cover: async reset asserted between clock edges during DRAIN -> all outputs 0 before the next edge; start after release gives a full frame.
REQ-035 SHALL cover: CROP_EN undefined -> 784 out_valid and 28 out_eol, done 1 cycle after the last.

Source files
------------

// File: rtl/conv_stream_ctrl_if.sv
// ---------------------------------------------------------------------------
// conv_stream_ctrl_if
// Purpose : bundles the image-RAM read port, the pixel path to/from the
//           convolution core and the cropped result stream of
//           conv_stream_ctrl into one interface.
// Signals :
//   mem_addr  [AW-1:0] pixel address into the synchronous image RAM
//   mem_rd_en          RAM read strobe
//   mem_data  [7:0]    RAM read data, valid 1 cycle after mem_rd_en
//   pxl_out   [7:0]    registered pixel towards the convolution core
//   conv_in   [7:0]    convolution result, 1 cycle after pxl_out
//   out_data  [7:0]    registered result
//   out_valid          result qualifier
//   out_eol            end-of-output-row flag (only together with out_valid)
// Modports: master = controller side, slave = RAM / conv core / sink side.
// ---------------------------------------------------------------------------
interface conv_stream_ctrl_if #(
    parameter int AW = 10
);
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en;
    logic [7:0]    mem_data;
    logic [7:0]    pxl_out;
    logic [7:0]    conv_in;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_eol;

    modport master (
        output mem_addr, mem_rd_en, pxl_out, out_data, out_valid, out_eol,
        input  mem_data, conv_in
    );

    modport slave (
        input  mem_addr, mem_rd_en, pxl_out, out_data, out_valid, out_eol,
        output mem_data, conv_in
    );
endinterface

// File: rtl/conv_stream_ctrl.sv
// ---------------------------------------------------------------------------
// conv_stream_ctrl
// Purpose : streams a DIM x DIM image out of a synchronous RAM, one pixel per
//           cycle, into a convolution core and qualifies the core's results.
//           A (row, col) tag travels alongside each pixel so that the result
//           stream can be cropped to the valid convolution window and flagged
//           at the end of each output row.
// Config  : `define CONV_STREAM_CTRL_CROP_EN to keep only results whose pixel
//           has row >= K-1 and col >= K-1; without it every pixel's result is
//           marked valid.
// Ports   :
//   clk    in   single clock, rising edge
//   reset  in   asynchronous active-high reset
//   start  in   frame-start request, honoured only when idle (and not aborted)
//   abort  in   cancels the frame in progress, no done pulse
//   bus    master modport of conv_stream_ctrl_if (RAM, conv core, results)
//   busy   out  high whenever the controller is not idle
//   done   out  1-cycle pulse, one cycle after the last result of a frame
// ---------------------------------------------------------------------------
module conv_stream_ctrl #(
    parameter int DIM = 28,
    parameter int K   = 5,
    parameter int AW  = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    conv_stream_ctrl_if.master  bus,
    output logic                busy,
    output logic                done
);

    localparam int            NPIX      = DIM * DIM;
    localparam int            CW        = (DIM > 2) ? $clog2(DIM) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
    localparam logic [CW-1:0] LAST_COL  = CW'(DIM - 1);
    localparam logic [CW-1:0] FIRST_KEEP = CW'(K - 1);
    // Drain covers the three pipeline stages behind the last address plus
    // the output register: four cycles.
    localparam logic [2:0]    DRAIN_LAST = 3'd3;
`ifdef CONV_STREAM_CTRL_CROP_EN
    localparam bit            CROP_EN   = 1'b1;
`else
    localparam bit            CROP_EN   = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [2:0]    drain_r;
    logic [AW-1:0] addr_r;
    logic          rd_en_r;
    logic [CW-1:0] row_r;
    logic [CW-1:0] col_r;
    // Tag stages: [0] RAM data valid, [1] pxl_out valid, [2] conv_in valid.
    logic          tag_vld_r [3];
    logic [CW-1:0] tag_row_r [3];
    logic [CW-1:0] tag_col_r [3];
    logic [7:0]    pxl_r;
    logic [7:0]    out_data_r;
    logic          out_valid_r;
    logic          out_eol_r;
    logic          busy_r;
    logic          done_r;

    // Decides whether a tagged pixel's result belongs to the output stream.
    function automatic logic keep_pixel(input logic [CW-1:0] r, input logic [CW-1:0] c);
        return !CROP_EN || ((r >= FIRST_KEEP) && (c >= FIRST_KEEP));
    endfunction

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; start together with abort is ignored in IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (addr_r == LAST_ADDR) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (drain_r == DRAIN_LAST) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Drain cycle counter, only advances while draining.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drain_r <= 3'd0;
        end else if ((state_r == ST_DRAIN) && !abort) begin
            drain_r <= drain_r + 3'd1;
        end else begin
            drain_r <= 3'd0;
        end
    end

    // Address generator with row/col counters that wrap at the line end.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_r  <= '0;
            rd_en_r <= 1'b0;
            row_r   <= '0;
            col_r   <= '0;
        end else if ((state_r == ST_IDLE) && (state_s == ST_FETCH)) begin
            addr_r  <= '0;
            rd_en_r <= 1'b1;
            row_r   <= '0;
            col_r   <= '0;
        end else if ((state_r == ST_FETCH) && (state_s == ST_FETCH)) begin
            addr_r  <= addr_r + AW'(1);
            rd_en_r <= 1'b1;
            if (col_r == LAST_COL) begin
                col_r <= '0;
                row_r <= row_r + CW'(1);
            end else begin
                col_r <= col_r + CW'(1);
            end
        end else begin
            rd_en_r <= 1'b0;
        end
    end

    // Tag pipeline following each issued address; abort empties it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                tag_vld_r[i] <= 1'b0;
                tag_row_r[i] <= '0;
                tag_col_r[i] <= '0;
            end
        end else begin
            if (abort) begin
                tag_vld_r[0] <= 1'b0;
                tag_vld_r[1] <= 1'b0;
                tag_vld_r[2] <= 1'b0;
            end else begin
                tag_vld_r[0] <= rd_en_r;
                tag_vld_r[1] <= tag_vld_r[0];
                tag_vld_r[2] <= tag_vld_r[1];
            end
            tag_row_r[0] <= row_r;
            tag_row_r[1] <= tag_row_r[0];
            tag_row_r[2] <= tag_row_r[1];
            tag_col_r[0] <= col_r;
            tag_col_r[1] <= tag_col_r[0];
            tag_col_r[2] <= tag_col_r[1];
        end
    end

    // Data path: RAM data into pxl_out, conv result into out_data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pxl_r      <= 8'd0;
            out_data_r <= 8'd0;
        end else begin
            if (tag_vld_r[0]) begin
                pxl_r <= bus.mem_data;
            end else begin
                pxl_r <= pxl_r;
            end
            out_data_r <= bus.conv_in;
        end
    end

    // Result qualifiers and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_eol_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            out_valid_r <= !abort && tag_vld_r[2] && keep_pixel(tag_row_r[2], tag_col_r[2]);
            out_eol_r   <= !abort && tag_vld_r[2] && keep_pixel(tag_row_r[2], tag_col_r[2])
                           && (tag_col_r[2] == LAST_COL);
            busy_r      <= (state_s != ST_IDLE);
            done_r      <= (state_s == ST_DONE);
        end
    end

    // Abort must silence the strobes within the current cycle, so the
    // registered strobes are gated by it on the way out.
    assign bus.mem_addr  = addr_r;
    assign bus.mem_rd_en = rd_en_r && !abort;
    assign bus.pxl_out   = pxl_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_valid = out_valid_r && !abort;
    assign bus.out_eol   = out_eol_r && !abort;
    assign busy          = busy_r;
    assign done          = done_r && !abort;

endmodule

// File: tb/tb_conv_stream_ctrl.sv
// ---------------------------------------------------------------------------
// tb_conv_stream_ctrl
// Self-checking bench: a frame-level model predicts, for every cycle, which
// address is issued, which pixel appears on pxl_out/out_data, whether it is
// valid / end-of-row, and when busy/done are high, from the start and abort
// cycles alone. Per-frame totals are pinned against hand-derived constants.
// ---------------------------------------------------------------------------
module tb_conv_stream_ctrl;

    localparam int DIM = 28;
    localparam int K   = 5;
    localparam int AW  = 10;
    localparam int N   = DIM * DIM;
`ifdef CONV_STREAM_CTRL_CROP_EN
    localparam bit CROP      = 1'b1;
    localparam int EXP_V     = 576;
    localparam int EXP_E     = 24;
    localparam int EXP_FIRST = 121;
`else
    localparam bit CROP      = 1'b0;
    localparam int EXP_V     = 784;
    localparam int EXP_E     = 28;
    localparam int EXP_FIRST = 5;
`endif

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic abort;
    logic busy;
    logic done;

    conv_stream_ctrl_if #(.AW(AW)) bus ();

    conv_stream_ctrl #(.DIM(DIM), .K(K), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .abort (abort),
        .bus   (bus.master),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [0:N-1];

    function automatic logic [7:0] conv_f(input logic [7:0] p);
        return (p ^ 8'h3C) + 8'd7;
    endfunction

    // Synchronous RAM and a one-cycle convolution core stand-in.
    always @(posedge clk) begin
        if (bus.mem_rd_en && (bus.mem_addr < AW'(N))) begin
            bus.mem_data <= ram[bus.mem_addr];
        end
        bus.conv_in <= conv_f(bus.pxl_out);
    end

    int checks = 0;
    int errors = 0;
    int cyc;
    bit act;
    int s;
    int n_v, n_e, first_v, last_v;
    int frames_dut = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, exp);
        end
    endtask

    task automatic check_cycle();
        bit alive, ab, exp_rd, in_rng, exp_v, exp_done;
        int j, p, r, c;
        alive = act && (cyc >= s + 1) && (cyc <= s + N + 5);
        ab    = alive && abort;
        chk("busy", busy, alive);
        exp_rd = alive && !ab && (cyc <= s + N);
        chk("mem_rd_en", bus.mem_rd_en, exp_rd);
        if (exp_rd) chk("mem_addr", bus.mem_addr, cyc - s - 1);
        p = cyc - s - 3;
        if (alive && !ab && p >= 0 && p < N) chk("pxl_out", bus.pxl_out, ram[p]);
        j = cyc - s - 5;
        in_rng = alive && !ab && j >= 0 && j < N;
        r = 0;
        c = 0;
        if (in_rng) begin
            r = j / DIM;
            c = j % DIM;
        end
        exp_v = in_rng && (!CROP || (r >= K - 1 && c >= K - 1));
        chk("out_valid", bus.out_valid, exp_v);
        chk("out_eol", bus.out_eol, exp_v && (c == DIM - 1));
        if (exp_v) chk("out_data", bus.out_data, conv_f(ram[j]));
        exp_done = alive && !ab && (cyc == s + N + 5);
        chk("done", done, exp_done);

        if (bus.out_valid) begin
            n_v++;
            if (first_v < 0) first_v = cyc - s;
            last_v = cyc;
        end
        if (bus.out_eol) n_e++;
        if (done) begin
            frames_dut++;
            chk("frame_valid_count", n_v, EXP_V);
            chk("frame_eol_count", n_e, EXP_E);
            chk("first_valid_offset", first_v, EXP_FIRST);
            chk("done_after_last_valid", cyc - last_v, 1);
            chk("done_offset", cyc - s, 789);
        end

        if (ab) begin
            act = 1'b0;
        end else if (alive && cyc == s + N + 5) begin
            act = 1'b0;
        end
        if (!alive && start && !abort) begin
            act = 1'b1;
            s = cyc;
            n_v = 0;
            n_e = 0;
            first_v = -1;
            last_v = 0;
        end
    endtask

    task automatic step(input logic st, input logic ab);
        @(negedge clk);
        start = st;
        abort = ab;
        #1;
        check_cycle();
        cyc++;
    endtask

    task automatic gap();
        int n;
        n = $urandom_range(6, 1);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(3, 0) == 0) step(1'b1, 1'b1);
            else step(1'b0, 1'b0);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++) ram[i] = 8'($urandom);
    endtask

    task automatic run_frame(input int spurious_at);
        step(1'b1, 1'b0);
        for (int i = 1; i < N + 8; i++) step((i == spurious_at) ? 1'b1 : 1'b0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_mem_addr"}, bus.mem_addr, 0);
        chk({tag, "_mem_rd_en"}, bus.mem_rd_en, 0);
        chk({tag, "_pxl_out"}, bus.pxl_out, 0);
        chk({tag, "_out_data"}, bus.out_data, 0);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_out_eol"}, bus.out_eol, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        act   = 1'b0;
        s     = 0;
        cyc   = 0;
        n_v = 0; n_e = 0; first_v = -1; last_v = 0;
        for (int i = 0; i < N; i++) ram[i] = 8'(i + 1);
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // Frame A: start in cycle 0, second start pulsed mid-FETCH.
        cyc = 0;
        run_frame(200);

        // Frame B: abort in the cycle address 300 is issued.
        gap();
        step(1'b1, 1'b0);
        for (int i = 1; i <= 300; i++) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);

        // Frame C: full frame after abort, random image.
        fill_random();
        run_frame($urandom_range(700, 2));

        // Frame D: asynchronous reset between edges while draining.
        gap();
        fill_random();
        step(1'b1, 1'b0);
        for (int i = 1; i <= N + 2; i++) step(1'b0, 1'b0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        act = 1'b0;
        cyc++;
        @(negedge clk);
        reset = 1'b0;
        cyc++;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);

        // Frame E: full frame after reset release, random image and gap.
        gap();
        fill_random();
        run_frame($urandom_range(780, 2));

        chk("completed_frames", frames_dut, 3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
